// File: rtl/trace_fifo.sv
// Multi-channel trace event FIFO: up to NCH events captured per cycle in channel
// order, overflow events dropped and counted, single-entry pop at the head.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int NCH   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trace_en,
    input  logic [NCH-1:0]             ev_valid,
    input  logic [32*NCH-1:0]          ev_pc,
    input  logic [32*NCH-1:0]          ev_addr,
    input  logic [32*NCH-1:0]          ev_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_chan,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    output logic [15:0]                drop_cnt,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (LW > 3) ? LW : 3;

    typedef struct packed {
        logic [1:0]  chan;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic [NCH-1:0]  wr_en;
    logic [AW-1:0]   wr_addr [NCH];
    logic [CW-1:0]   free, slot, n_push, n_drop;
    logic [16:0]     drop_sum;
    logic            pop;
    entry_t          head;

    always_comb begin
        // Room is judged before any same-cycle pop, so a pop never frees a slot
        // for this cycle's pushes.
        free   = CW'(DEPTH) - CW'(level_q);
        slot   = '0;
        n_push = '0;
        n_drop = '0;
        wr_en  = '0;
        for (int k = 0; k < NCH; k++) begin
            wr_addr[k] = wptr_q;
            if (trace_en && ev_valid[k]) begin
                if (slot < free) begin
                    wr_en[k]   = 1'b1;
                    wr_addr[k] = wptr_q + AW'(slot);
                    n_push     = n_push + 1'b1;
                end else begin
                    n_drop = n_drop + 1'b1;
                end
                slot = slot + 1'b1;
            end
        end

        pop     = (level_q != '0) && out_ready;
        level_d = level_q + LW'(n_push) - LW'(pop);
        wptr_d  = wptr_q + AW'(n_push);
        rptr_d  = rptr_q + AW'(pop);

        drop_sum = {1'b0, drop_cnt_q} + 17'(n_drop);
        if (clr_ovf) begin
            ovf_d      = (n_drop != '0);
            drop_cnt_d = 16'(n_drop);
        end else begin
            ovf_d      = ovf_q | (n_drop != '0);
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (wr_en[k]) begin
                mem_q[wr_addr[k]] <= '{chan: 2'(k),
                                      pc:   ev_pc[32*k +: 32],
                                      addr: ev_addr[32*k +: 32],
                                      data: ev_data[32*k +: 32]};
            end
        end
    end

    always_comb begin
        head      = mem_q[rptr_q];
        out_valid = (level_q != '0);
        out_chan  = out_valid ? head.chan : 2'd0;
        out_pc    = out_valid ? head.pc   : 32'd0;
        out_addr  = out_valid ? head.addr : 32'd0;
        out_data  = out_valid ? head.data : 32'd0;
    end

    assign level    = level_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_trace_fifo.sv
// Randomized and directed bench for trace_fifo (DEPTH=4, NCH=2) against a
// queue-based reference model.
module tb_trace_fifo;

    localparam int DEPTH = 4;
    localparam int NCH   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic [1:0]  ev_valid;
    logic [63:0] ev_pc, ev_addr, ev_data;
    logic        out_valid, out_ready;
    logic [1:0]  out_chan;
    logic [31:0] out_pc, out_addr, out_data;
    logic [2:0]  level;
    logic        ovf;
    logic [15:0] drop_cnt;
    logic        clr_ovf;

    trace_fifo #(.DEPTH(DEPTH), .NCH(NCH)) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en), .ev_valid(ev_valid),
        .ev_pc(ev_pc), .ev_addr(ev_addr), .ev_data(ev_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .level(level), .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] pc, addr, data;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   m_drop;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (q.size() != 0);
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("out_chan",  64'(out_chan),  v ? 64'(q[0].ch)   : 64'd0);
        chk("out_pc",    64'(out_pc),    v ? 64'(q[0].pc)   : 64'd0);
        chk("out_addr",  64'(out_addr),  v ? 64'(q[0].addr) : 64'd0);
        chk("out_data",  64'(out_data),  v ? 64'(q[0].data) : 64'd0);
        chk("level",     64'(level),     64'(q.size()));
        chk("ovf",       64'(ovf),       64'(m_ovf));
        chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
    endtask

    // Drive one cycle of inputs, check current state, advance the model, clock.
    task automatic step(input logic en, input logic [1:0] v, input logic rdy,
                        input logic clr, input logic [63:0] pcs);
        ent_t add[$];
        int   free, drops;
        bit   pop;
        trace_en  = en;
        ev_valid  = v;
        out_ready = rdy;
        clr_ovf   = clr;
        ev_pc     = pcs;
        ev_addr   = {$urandom(), $urandom()};
        ev_data   = {$urandom(), $urandom()};
        #1;
        check_outputs();

        free  = DEPTH - q.size();
        pop   = (q.size() != 0) && rdy;
        drops = 0;
        for (int k = 0; k < NCH; k++) begin
            if (en && v[k]) begin
                if (add.size() < free)
                    add.push_back('{ch: 2'(k), pc: ev_pc[32*k +: 32],
                                   addr: ev_addr[32*k +: 32], data: ev_data[32*k +: 32]});
                else
                    drops++;
            end
        end
        if (pop) void'(q.pop_front());
        foreach (add[i]) q.push_back(add[i]);
        if (clr) begin
            m_ovf  = (drops > 0);
            m_drop = drops;
        end else begin
            if (drops > 0) m_ovf = 1'b1;
            m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rpc();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        reset = 1'b0; trace_en = 1'b0; ev_valid = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        ev_pc = '0; ev_addr = '0; ev_data = '0;
        m_ovf = 1'b0; m_drop = 0;
        #12;
        check_outputs();
        reset = 1'b1;
        @(posedge clk); #1;

        // Two events in one cycle, popped in channel order.
        step(1, 2'b11, 0, 0, {32'h3004, 32'h3000});
        chk("two_push_level", 64'(level), 64'd2);
        chk("two_push_head", 64'(out_pc), 64'h3000);
        step(0, 2'b00, 1, 0, rpc());
        chk("second_chan", 64'(out_chan), 64'd1);
        chk("second_pc", 64'(out_pc), 64'h3004);
        step(0, 2'b00, 1, 0, rpc());
        chk("empty_again", 64'(out_valid), 64'd0);

        // Fill to 3, then 2 candidates with a pop: ch0 kept, ch1 dropped.
        step(1, 2'b11, 0, 0, rpc());
        step(1, 2'b01, 0, 0, rpc());
        step(1, 2'b11, 1, 0, rpc());
        chk("ovf_level", 64'(level), 64'd3);
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("ovf_drop1", 64'(drop_cnt), 64'd1);

        // Fill to full; pop on full with both channels valid drops both.
        step(1, 2'b01, 0, 0, rpc());
        step(1, 2'b11, 1, 0, rpc());
        chk("full_pop_level", 64'(level), 64'(DEPTH - 1));
        chk("full_pop_drop", 64'(drop_cnt), 64'd3);
        step(1, 2'b01, 0, 0, rpc());

        // Disabled tracing on a full FIFO changes nothing.
        step(0, 2'b11, 0, 0, rpc());
        chk("en0_level", 64'(level), 64'(DEPTH));
        chk("en0_drop", 64'(drop_cnt), 64'd3);

        // Drain, then single events through the pointer wrap.
        for (int i = 0; i < DEPTH; i++) step(0, 2'b00, 1, 0, rpc());
        for (int i = 0; i < 10; i++) begin
            step(1, 2'b01 << (i % 2), 0, 0, rpc());
            step(0, 2'b00, 1, 0, rpc());
        end
        chk("wrap_empty_pc", 64'(out_pc), 64'd0);

        // Saturate drop_cnt, then clear with one simultaneous drop.
        for (int i = 0; i < 2; i++) step(1, 2'b11, 0, 0, rpc());
        for (int i = 0; i < 33000; i++) step(1, 2'b11, 0, 0, rpc());
        chk("sat", 64'(drop_cnt), 64'hFFFF);
        for (int i = 0; i < 2; i++) step(0, 2'b00, 1, 0, rpc());
        step(1, 2'b01, 0, 0, rpc());
        step(1, 2'b11, 0, 1, rpc());
        chk("clr_drop", 64'(drop_cnt), 64'd1);
        chk("clr_ovf", 64'(ovf), 64'd1);
        step(0, 2'b00, 0, 1, rpc());
        chk("clr_only", 64'(drop_cnt), 64'd0);

        // Asynchronous reset mid-stream at level 3.
        for (int i = 0; i < DEPTH; i++) step(0, 2'b00, 1, 0, rpc());
        step(1, 2'b11, 0, 0, rpc());
        step(1, 2'b01, 0, 0, rpc());
        chk("pre_rst_level", 64'(level), 64'd3);
        reset = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        q.delete(); m_ovf = 1'b0; m_drop = 0;
        reset = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) != 0), 2'($urandom()), 1'($urandom()),
                 ($urandom_range(0, 40) == 0), rpc());
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
